multicycle_control_unit: RTL
============================

# multicycle_control_unit

Moore-style control FSM for the multi-cycle RISC-V datapath, the sequential successor to the single-cycle control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the datapath mux selects and write strobes. It stalls on a memory ready handshake. Parameters select which optional instruction classes are decoded, and a retired-instruction counter is included. It sits between the instruction register opcode field, the ALU zero flag and memory ready on the input side, and the shared-memory multi-cycle datapath on the output side.

## Interface
Parameters:
- ENABLE_IMM_ALU, 1, decode I-type ALU opcode 0010011; when 0 that opcode is illegal
- ENABLE_JAL, 1, decode JAL opcode 1101111; when 0 that opcode is illegal
- RETIRE_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instruction register bits [6:0]; the instruction register holds them stable from DECODE until the next FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake; the current access completes in a cycle where it is 1
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register load enable
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write enable
- result_src  out  2  00 = ALUOut, 01 = memory data register, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded
- retired  out  RETIRE_W  count of completed instructions
- state  out  4  current state encoding (debug)

## Operation
State encodings are fixed as follows: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, ALUWB=7, EXEC_I=8, JAL=9, BEQ=10. Codes 11–15 are unreachable; if entered, the FSM goes to FETCH on the next edge.

Every output not listed for a state is 0.

- **FETCH:**
  - Drives adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - Drives ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- **DECODE:**
  - Drives alu_src_a=01, alu_src_b=01, alu_op=00, which computes the branch/jump target.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 1100011 -> BEQ
    - 0010011 -> EXEC_I (only if ENABLE_IMM_ALU)
    - 1101111 -> JAL (only if ENABLE_JAL)
    - any other opcode -> illegal=1 and next state FETCH; the instruction is not retired.
- **MEMADR:** drives alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMRD if opcode=0000011, otherwise to MEMWR.
- **MEMRD:** drives adr_src=1, mem_read=1. Stays until mem_ready=1, then goes to MEMWB.
- **MEMWB:** drives result_src=01, reg_write=1. Goes to FETCH.
- **MEMWR:** drives adr_src=1, mem_write=1. Stays until mem_ready=1, then goes to FETCH.
- **EXEC_R:** drives alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- **EXEC_I:** drives alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
- **ALUWB:** drives result_src=00, reg_write=1. Goes to FETCH.
- **JAL:** drives alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB.
- **BEQ:** drives alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Goes to FETCH.

Retired counter:
- Increments by 1 on each edge that moves the FSM into FETCH from MEMWB, MEMWR, ALUWB or BEQ.
- Does not increment on the illegal path.
- Wraps modulo 2^RETIRE_W.

## Timing
- All datapath controls are combinational decodes of the state register (plus zero and mem_ready). There are no registered outputs besides state and retired.
- While rst_n=0:
  - state=FETCH and retired=0, asynchronously.
  - pc_write, ir_write, mem_read, mem_write, reg_write and illegal are forced to 0.
  - The select outputs take their FETCH values.
- After rst_n deasserts, the first rising edge samples in FETCH.
- Reset asserted mid-instruction aborts it immediately: no further strobes are driven and retired is not incremented.
- Latency with mem_ready held at 1:
  - load: 5 cycles
  - store: 4 cycles
  - R-type and I-type: 4 cycles
  - JAL: 4 cycles
  - BEQ: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- While stalled, mem_read and mem_write stay asserted and the address select is held.
- The FSM must not depend on mem_ready in any other state.

## Test plan
- **Reset:** assert rst_n=0 mid-MEMRD -> state=0 and all strobes 0 immediately. Release reset, mem_ready=1, opcode=0110011 -> state sequence 0,1,6,7,0; reg_write=1 only in state 7; retired=1.
- **Load with stalls:** opcode=0000011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> load completes in 10 cycles; ir_write pulses once; retired +1.
- **Branch:** opcode=1100011 -> 3 cycles. pc_write=1 in BEQ with zero=1; pc_write=0 with zero=0. retired increments in both cases.
- **Optional classes:** ENABLE_JAL=0, opcode=1101111 -> illegal=1 for one cycle in DECODE, return to FETCH, retired unchanged. With ENABLE_JAL=1 -> states 0,1,9,7,0.
- **Counter wrap:** RETIRE_W=4, run 17 R-type instructions -> retired=1.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: IR opcode / ALU flag / memory handshake in, datapath controls out.
interface multicycle_control_unit_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic [6:0]          opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                adr_src;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic [1:0]          result_src;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;
  logic [3:0]          state;

  // Control unit side
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
    output result_src, alu_src_a, alu_src_b, alu_op, illegal, retired, state
  );

  // Datapath side
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, alu_op, illegal, retired, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the shared-memory multi-cycle RISC-V datapath, with a
// retired-instruction counter. Controls are combinational decodes of the state.
module multicycle_control_unit #(
  parameter bit          ENABLE_IMM_ALU = 1'b1,
  parameter bit          ENABLE_JAL     = 1'b1,
  parameter int unsigned RETIRE_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_unit_if.master  bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StAluWb  = 4'd7,
    StExecI  = 4'd8,
    StJal    = 4'd9,
    StBeq    = 4'd10
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  logic                legal;

  // Opcode legality under the enabled instruction classes
  always_comb begin
    legal = (bus.opcode == OpLoad) || (bus.opcode == OpStore) ||
            (bus.opcode == OpR)    || (bus.opcode == OpBranch) ||
            (ENABLE_IMM_ALU && (bus.opcode == OpImm)) ||
            (ENABLE_JAL && (bus.opcode == OpJal));
  end

  // Next-state logic; retire flags completion of an instruction on its way back to FETCH
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpBranch:        state_d = StBeq;
          OpImm:           state_d = ENABLE_IMM_ALU ? StExecI : StFetch;
          OpJal:           state_d = ENABLE_JAL ? StJal : StFetch;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (bus.opcode == OpLoad) ? StMemRd : StMemWr;
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR, StExecI, StJal: state_d = StAluWb;
      StAluWb, StBeq: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default:  state_d = StFetch;
    endcase
    retired_d = retire ? retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1} : retired_q;
  end

  // State and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Datapath control decode; strobes are held low while in reset
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        bus.mem_read   = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
      end
      StDecode: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.illegal   = !legal;
      end
      StMemAdr: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      StMemRd: begin
        bus.adr_src  = 1'b1;
        bus.mem_read = 1'b1;
      end
      StMemWb: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      StMemWr: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      StExecR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
      end
      StExecI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
      end
      StAluWb:  bus.reg_write = 1'b1;
      StJal: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
      end
      StBeq: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        bus.pc_write  = bus.zero;
      end
      default: ;
    endcase
    if (!rst_n) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
      bus.illegal   = 1'b0;
    end
    bus.retired = retired_q;
    bus.state   = state_q;
  end

endmodule
